// File: rtl/keypad_scanner_if.sv
// Keypad pin / event bundle for keypad_scanner.
//   slave  : scanner side (samples Row, drives Col and the key event outputs)
//   master : pin/consumer side (drives Row, observes everything else)
// Signals:
//   Row          NUM_ROWS  keypad rows, active-low
//   Col          NUM_COLS  column drive, active-low, at most one bit low
//   key_code     KW        accepted key index = row*NUM_COLS + col
//   key_valid    1         1-cycle pulse, new key accepted
//   key_release  1         1-cycle pulse, accepted key released
//   key_down     1         level, accepted key held
//   multi_key    1         level, stable scan shows >1 key
interface keypad_scanner_if #(
  parameter int NUM_COLS = 4,
  parameter int NUM_ROWS = 4,
  parameter int KW       = (NUM_ROWS*NUM_COLS > 1) ? $clog2(NUM_ROWS*NUM_COLS) : 1
);
  logic [NUM_ROWS-1:0] Row;
  logic [NUM_COLS-1:0] Col;
  logic [KW-1:0]       key_code;
  logic                key_valid;
  logic                key_release;
  logic                key_down;
  logic                multi_key;

  modport master (output Row,
                  input  Col, key_code, key_valid, key_release, key_down, multi_key);
  modport slave  (input  Row,
                  output Col, key_code, key_valid, key_release, key_down, multi_key);
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner. Drives one column low per slot, samples the synchronised
// active-low rows once per slot, debounces over whole scans and emits press/release
// events with a linear key index.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   kp   keypad_scanner_if.slave (Row in; Col, key_code, key_valid, key_release,
//        key_down, multi_key out)
module keypad_scanner #(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int COL_CYCLES     = 100000,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.slave   kp
);
  localparam int KW = (NUM_ROWS*NUM_COLS > 1) ? $clog2(NUM_ROWS*NUM_COLS) : 1;
  localparam int CW = $clog2(NUM_COLS);
  localparam int SW = $clog2(COL_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {S_DRIVE, S_SAMPLE, S_HOLD} state_e;
  typedef enum logic [1:0] {R_NONE, R_KEY, R_MULTI} raw_kind_e;
  typedef struct packed {
    raw_kind_e     kind;
    logic [KW-1:0] idx;   // zero unless kind == R_KEY so whole-struct compare works
  } raw_t;

  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic                run_q, run_d;
  state_e              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [CW-1:0]       col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic [1:0]          acc_cnt_q, acc_cnt_d;
  logic [KW-1:0]       acc_idx_q, acc_idx_d;
  raw_t                prev_q, prev_d;
  logic [DW-1:0]       stable_q, stable_d;
  logic [KW-1:0]       key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_release_q, key_release_d;
  logic                key_down_q, key_down_d;
  logic                multi_q, multi_d;

  logic                last_slot, eval, reach;
  logic [KW-1:0]       hit_idx;
  raw_t                raw;

  always_comb begin
    run_d         = run_q;
    state_d       = state_q;
    slot_d        = slot_q;
    col_idx_d     = col_idx_q;
    acc_cnt_d     = acc_cnt_q;
    acc_idx_d     = acc_idx_q;
    prev_d        = prev_q;
    stable_d      = stable_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_down_d    = key_down_q;
    multi_d       = multi_q;
    hit_idx       = '0;
    reach         = 1'b0;
    raw           = '0;

    last_slot = (slot_q == SW'(COL_CYCLES - 1));
    eval      = run_q && last_slot && (col_idx_q == CW'(NUM_COLS - 1));

    // First cycle out of reset only arms the scan; counters are already at
    // column 0 / slot 0, so the next cycle is the first driven cycle.
    if (!run_q) begin
      run_d = 1'b1;
    end else begin
      slot_d = last_slot ? '0 : slot_q + 1'b1;
      if (last_slot)
        col_idx_d = (col_idx_q == CW'(NUM_COLS - 1)) ? '0 : col_idx_q + 1'b1;
      case (state_q)
        S_DRIVE:  if (slot_q == SW'(SETTLE_CYCLES - 1)) state_d = S_SAMPLE;
        S_SAMPLE: state_d = last_slot ? S_DRIVE : S_HOLD;
        S_HOLD:   if (last_slot) state_d = S_DRIVE;
        default:  state_d = S_DRIVE;
      endcase
    end

    // Column drive is registered from the next column index so it changes
    // on the same edge as the slot counter wraps.
    col_d            = '1;
    col_d[col_idx_d] = 1'b0;

    if (run_q && state_q == S_SAMPLE) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!row_s2_q[r]) begin
          hit_idx = KW'(r*NUM_COLS + int'(col_idx_q));
          if (acc_cnt_d == 2'd0 || hit_idx < acc_idx_d) acc_idx_d = hit_idx;
          if (acc_cnt_d != 2'd2) acc_cnt_d = acc_cnt_d + 2'd1;
        end
      end
    end

    // EVAL uses the _d accumulators so a sample on the final cycle still counts.
    if (eval) begin
      case (acc_cnt_d)
        2'd0:    raw.kind = R_NONE;
        2'd1:    begin raw.kind = R_KEY; raw.idx = acc_idx_d; end
        default: raw.kind = R_MULTI;
      endcase
      if (raw == prev_q) begin
        if (stable_q != DW'(DEBOUNCE_SCANS)) stable_d = stable_q + 1'b1;
        reach = (stable_q == DW'(DEBOUNCE_SCANS - 1));
      end else begin
        prev_d   = raw;
        stable_d = DW'(1);
        reach    = (DEBOUNCE_SCANS == 1);
      end
      acc_cnt_d = '0;
      acc_idx_d = '0;

      if (reach) begin
        case (raw.kind)
          R_KEY: begin
            multi_d = 1'b0;
            if (!key_down_q || raw.idx != key_code_q) begin
              key_valid_d = 1'b1;
              key_code_d  = raw.idx;
              key_down_d  = 1'b1;
            end
          end
          R_NONE: begin
            multi_d = 1'b0;
            if (key_down_q) begin
              key_release_d = 1'b1;
              key_down_d    = 1'b0;
            end
          end
          default: multi_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q      <= '1;   // idle level: no key
      row_s2_q      <= '1;
      run_q         <= 1'b0;
      state_q       <= S_DRIVE;
      slot_q        <= '0;
      col_idx_q     <= '0;
      col_q         <= '1;
      acc_cnt_q     <= '0;
      acc_idx_q     <= '0;
      prev_q        <= '0;
      stable_q      <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_down_q    <= 1'b0;
      multi_q       <= 1'b0;
    end else begin
      row_s1_q      <= kp.Row;
      row_s2_q      <= row_s1_q;
      run_q         <= run_d;
      state_q       <= state_d;
      slot_q        <= slot_d;
      col_idx_q     <= col_idx_d;
      col_q         <= col_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_idx_q     <= acc_idx_d;
      prev_q        <= prev_d;
      stable_q      <= stable_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_down_q    <= key_down_d;
      multi_q       <= multi_d;
    end
  end

  assign kp.Col         = col_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_release = key_release_q;
  assign kp.key_down    = key_down_q;
  assign kp.multi_key   = multi_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model maps pressed keys onto Row from
// Col; expected key events (kind, code, cycle) are queued when stimulus is applied and
// popped by a monitor whenever the DUT pulses key_valid/key_release.
module tb_keypad_scanner;
  localparam int NC = 4, NR = 4, CC = 16, SC = 4, DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) kp ();

  keypad_scanner #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .COL_CYCLES(CC),
    .SETTLE_CYCLES(SC), .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  logic [NR*NC-1:0] pressed = '0;
  always_comb begin
    kp.Row = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC + c] && !kp.Col[c]) kp.Row[r] = 1'b0;
  end

  // Cycle number since reset release: cycle 0 is the first driven cycle.
  int cyc = -1;
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  typedef struct {
    bit rel;
    int code;
    int at;
  } ev_t;
  ev_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && (kp.key_valid || kp.key_release)) begin
      chk("valid_release_exclusive", {31'd0, kp.key_valid & kp.key_release}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, kp.key_valid, kp.key_release}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", {31'd0, kp.key_release}, {31'd0, e.rel});
        chk("event_code", {28'd0, kp.key_code}, e.code);
        chk("event_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_ev(input bit rel, input int code, input int at);
    ev_t e;
    e.rel = rel; e.code = code; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic chk_levels(input string tag, input int down, input int multi, input int code);
    chk({tag, "_key_down"}, {31'd0, kp.key_down}, down);
    chk({tag, "_multi_key"}, {31'd0, kp.multi_key}, multi);
    chk({tag, "_key_code"}, {28'd0, kp.key_code}, code);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset state and scan order.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_col", {28'd0, kp.Col}, 32'hF);
    chk("reset_valid", {31'd0, kp.key_valid}, 0);
    chk("reset_release", {31'd0, kp.key_release}, 0);
    chk_levels("reset", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2*NC*CC; i++) begin
      chk("col_scan", {28'd0, kp.Col}, 15 ^ (1 << ((i / CC) % NC)));
      @(negedge clk);
    end
    wait_until(200);
    chk_levels("idle", 0, 0, 0);

    // Test 2: hold index 6 (row 1, col 2) from scan 5; accepted after scan 7.
    wait_until(256);
    pressed[6] = 1'b1;
    expect_ev(1'b0, 6, 448);
    wait_until(447);
    chk_levels("press6_before", 0, 0, 0);
    wait_until(449);
    chk_levels("press6_after", 1, 0, 6);

    // Test 4: release from scan 9; release pulse after scan 11, code holds.
    wait_until(512);
    pressed = '0;
    expect_ev(1'b1, 6, 704);
    wait_until(703);
    chk_levels("rel6_before", 1, 0, 6);
    wait_until(705);
    chk_levels("rel6_after", 0, 0, 6);

    // Test 3: one-scan bounce on index 6 must not be accepted.
    wait_until(768);
    pressed[6] = 1'b1;
    wait_until(832);
    pressed = '0;
    wait_until(1024);
    chk_levels("bounce", 0, 0, 6);

    // Test 5: indices 0 and 5 together -> multi_key, then release -> cleared.
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    wait_until(1215);
    chk_levels("multi_before", 0, 0, 6);
    wait_until(1216);
    chk_levels("multi_set", 0, 1, 6);
    wait_until(1280);
    pressed = '0;
    wait_until(1471);
    chk_levels("multi_hold", 0, 1, 6);
    wait_until(1472);
    chk_levels("multi_clear", 0, 0, 6);

    // Key change while held: 6 accepted, then 9 replaces it with no release.
    wait_until(1536);
    pressed[6] = 1'b1;
    expect_ev(1'b0, 6, 1728);
    wait_until(1792);
    pressed = '0;
    pressed[9] = 1'b1;
    expect_ev(1'b0, 9, 1984);
    wait_until(1983);
    chk_levels("switch_before", 1, 0, 6);
    wait_until(1985);
    chk_levels("switch_after", 1, 0, 9);

    // Test 6: one-cycle reset mid-slot with key 9 held; re-accept takes 3 scans.
    wait_until(2000);
    chk("queue_drained_pre_reset", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_col", {28'd0, kp.Col}, 32'hF);
    chk_levels("midreset", 0, 0, 0);
    rst = 1'b0;
    expect_ev(1'b0, 9, 3*NC*CC);
    @(negedge clk);
    chk("restart_col0", {28'd0, kp.Col}, 32'hE);
    wait_until(CC);
    chk("restart_col1", {28'd0, kp.Col}, 32'hD);
    wait_until(3*NC*CC - 1);
    chk_levels("reaccept_before", 0, 0, 0);
    wait_until(3*NC*CC + 1);
    chk_levels("reaccept_after", 1, 0, 9);

    wait_until(260);
    chk("queue_drained_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
